// File: rtl/tlc_demand_scheduler.sv
// Demand scheduler and seconds timer for the highway/farm intersection light controller.
// Latches farm/pedestrian demand, grants the end of highway green, and handles emergency preemption.
module tlc_demand_scheduler #(
    parameter int TICKS_PER_SEC = 100,
    parameter int MIN_GREEN     = 30,
    parameter int MAX_WAIT      = 60
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        RstCount,
    input  logic        hwyGreen,
    input  logic        farmSensor,
    input  logic        pedButton,
    input  logic        emergency,
    output logic [30:0] Count,
    output logic        secTick,
    output logic        farmReq,
    output logic        preempt,
    output logic [1:0]  schedState
);

    localparam int          PW          = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICKS_PER_SEC - 1);
    localparam logic [30:0] COUNT_MAX   = {31{1'b1}};
    localparam logic [30:0] MIN_GREEN_C = 31'(MIN_GREEN);
    localparam logic [7:0]  MAX_WAIT_C  = 8'(MAX_WAIT);
    localparam logic [7:0]  WAIT_MAX    = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PENDING = 2'b01,
        SERVE   = 2'b10,
        PREEMPT = 2'b11
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] pre;
    logic          farm_pend;
    logic          ped_pend;
    logic [7:0]    wait_cnt;
    logic          wrap;
    logic          any_req;
    logic          req_nxt;
    logic          entering_serve;
    logic          entering_pending;

    assign wrap             = (pre == PRE_LAST);
    assign any_req          = farm_pend | ped_pend | farmSensor | pedButton;
    assign entering_serve   = (state_nxt == SERVE) && (state != SERVE);
    assign entering_pending = (state_nxt == PENDING) && (state != PENDING);
    assign schedState       = state;

    // Seconds prescaler and saturating elapsed-seconds count; RstCount beats a wrap.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pre     <= '0;
            Count   <= 31'd0;
            secTick <= 1'b0;
        end else if (RstCount) begin
            pre     <= '0;
            Count   <= 31'd0;
            secTick <= 1'b0;
        end else if (wrap) begin
            pre     <= '0;
            secTick <= 1'b1;
            if (Count != COUNT_MAX) begin
                Count <= Count + 31'd1;
            end else begin
                Count <= Count;
            end
        end else begin
            pre     <= pre + PW'(1);
            secTick <= 1'b0;
        end
    end

    // Next-state decision; emergency overrides every state.
    always_comb begin
        state_nxt = state;
        if (emergency) begin
            state_nxt = PREEMPT;
        end else begin
            case (state)
                IDLE:    state_nxt = any_req ? PENDING : IDLE;
                PENDING: state_nxt = (farmReq && !hwyGreen) ? SERVE : PENDING;
                SERVE:   state_nxt = hwyGreen ? (any_req ? PENDING : IDLE) : SERVE;
                PREEMPT: state_nxt = any_req ? PENDING : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Grant is only meaningful while highway green runs in PENDING.
    always_comb begin
        req_nxt = 1'b0;
        if ((state == PENDING) && !emergency && hwyGreen) begin
            req_nxt = (Count >= MIN_GREEN_C) || (wait_cnt >= MAX_WAIT_C);
        end else begin
            req_nxt = 1'b0;
        end
    end

    // State and registered controller outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            farmReq <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state   <= state_nxt;
            farmReq <= req_nxt;
            preempt <= emergency;
        end
    end

    // Demand latches: cleared when service starts, but a request in that same cycle still sticks.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            farm_pend <= 1'b0;
            ped_pend  <= 1'b0;
        end else if (entering_serve) begin
            farm_pend <= farmSensor;
            ped_pend  <= pedButton;
        end else begin
            farm_pend <= farm_pend | farmSensor;
            ped_pend  <= ped_pend | pedButton;
        end
    end

    // Age of the pending request in seconds, restarted on every entry to PENDING.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wait_cnt <= 8'd0;
        end else if (entering_pending) begin
            wait_cnt <= 8'd0;
        end else if ((state == PENDING) && secTick && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= wait_cnt;
        end
    end

endmodule

// File: tb/tb_tlc_demand_scheduler.sv
// Bench for tlc_demand_scheduler: directed scenarios then random traffic, all checked
// cycle by cycle against a behavioural model of the scheduling rules.
module tb_tlc_demand_scheduler;

    localparam int TPS  = 4;
    localparam int MING = 12;
    localparam int MAXW = 20;

    localparam int S_IDLE  = 0;
    localparam int S_PEND  = 1;
    localparam int S_SERVE = 2;
    localparam int S_PRE   = 3;

    logic        Clk        = 1'b0;
    logic        Rst        = 1'b1;
    logic        RstCount   = 1'b0;
    logic        hwyGreen   = 1'b0;
    logic        farmSensor = 1'b0;
    logic        pedButton  = 1'b0;
    logic        emergency  = 1'b0;
    logic [30:0] Count;
    logic        secTick;
    logic        farmReq;
    logic        preempt;
    logic [1:0]  schedState;

    int n_cmp = 0;
    int n_err = 0;

    // model of the intersection scheduler, in seconds and plain integers
    longint m_count;
    int     m_cyc;
    bit     m_tick;
    bit     m_farm;
    bit     m_ped;
    int     m_wait;
    int     m_state;
    bit     m_req;
    bit     m_pre;

    tlc_demand_scheduler #(
        .TICKS_PER_SEC(TPS),
        .MIN_GREEN    (MING),
        .MAX_WAIT     (MAXW)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .RstCount  (RstCount),
        .hwyGreen  (hwyGreen),
        .farmSensor(farmSensor),
        .pedButton (pedButton),
        .emergency (emergency),
        .Count     (Count),
        .secTick   (secTick),
        .farmReq   (farmReq),
        .preempt   (preempt),
        .schedState(schedState)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_cyc = 0; m_tick = 0; m_farm = 0; m_ped = 0;
        m_wait = 0; m_state = S_IDLE; m_req = 0; m_pre = 0;
    endtask

    task automatic model_step();
        int n_state;
        int n_wait;
        bit any_req;
        bit n_req;
        bit n_farm;
        bit n_ped;
        any_req = m_farm || m_ped || (farmSensor === 1'b1) || (pedButton === 1'b1);
        if (emergency) n_state = S_PRE;
        else if (m_state == S_IDLE) n_state = any_req ? S_PEND : S_IDLE;
        else if (m_state == S_PEND) n_state = (m_req && !hwyGreen) ? S_SERVE : S_PEND;
        else if (m_state == S_SERVE) n_state = hwyGreen ? (any_req ? S_PEND : S_IDLE) : S_SERVE;
        else n_state = any_req ? S_PEND : S_IDLE;

        n_req = (m_state == S_PEND) && !emergency && hwyGreen && (m_count >= MING || m_wait >= MAXW);

        if (n_state == S_SERVE && m_state != S_SERVE) begin
            n_farm = farmSensor; n_ped = pedButton;
        end else begin
            n_farm = m_farm || farmSensor; n_ped = m_ped || pedButton;
        end

        if (n_state == S_PEND && m_state != S_PEND) n_wait = 0;
        else if (m_state == S_PEND && m_tick && m_wait < 255) n_wait = m_wait + 1;
        else n_wait = m_wait;

        if (RstCount) begin
            m_cyc = 0; m_count = 0; m_tick = 0;
        end else if (m_cyc + 1 >= TPS) begin
            m_cyc = 0; m_tick = 1;
            if (m_count < 64'h7FFF_FFFF) m_count = m_count + 1;
        end else begin
            m_cyc = m_cyc + 1; m_tick = 0;
        end

        m_state = n_state; m_req = n_req; m_farm = n_farm; m_ped = n_ped;
        m_wait = n_wait; m_pre = emergency;
    endtask

    task automatic compare_all();
        check("count",    Count,        m_count);
        check("sec_tick", secTick,      m_tick);
        check("farm_req", farmReq,      m_req);
        check("preempt",  preempt,      m_pre);
        check("state",    schedState,   m_state);
        check("wait_cnt", dut.wait_cnt, m_wait);
    endtask

    task automatic cycle();
        if (Rst) model_reset();
        else model_step();
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    task automatic run_until_count(input string tag, input int target, input int budget);
        int k = 0;
        while (Count != 31'(target) && k < budget) begin
            cycle();
            k++;
        end
        check(tag, Count, target);
    endtask

    initial begin
        int ticks;
        int k;
        model_reset();

        // reset and prescaler
        cycle();
        cycle();
        Rst = 1'b0;
        check("rst_count", Count, 0);
        check("rst_state", schedState, 0);
        check("rst_req",   farmReq, 0);
        ticks = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            ticks += int'(secTick);
            if (i == 4) check("count_at_4", Count, 1);
        end
        check("count_at_20", Count, 5);
        check("tick_pulses", ticks, 5);
        RstCount = 1'b1;
        cycle();
        RstCount = 1'b0;
        check("rstcount_clear", Count, 0);

        // farm request honoured at minimum green
        hwyGreen = 1'b1;
        RstCount = 1'b1;
        cycle();
        RstCount = 1'b0;
        run_until_count("reach_5", 5, 100);
        farmSensor = 1'b1;
        cycle();
        farmSensor = 1'b0;
        check("farm_to_pending", schedState, S_PEND);
        run_until_count("reach_min", MING, 200);
        check("req_before_min", farmReq, 0);
        cycle();
        check("req_at_min", farmReq, 1);
        hwyGreen = 1'b0;
        cycle();
        check("serve_state", schedState, S_SERVE);
        check("serve_req_low", farmReq, 0);

        // re-latch during serve
        farmSensor = 1'b1;
        cycle();
        farmSensor = 1'b0;
        repeat (3) cycle();
        hwyGreen = 1'b1;
        cycle();
        check("relatch_pending", schedState, S_PEND);

        // preemption from PENDING with grant active
        cycle();
        check("req_before_emerg", farmReq, 1);
        emergency = 1'b1;
        cycle();
        check("preempt_on", preempt, 1);
        check("preempt_req_low", farmReq, 0);
        check("preempt_state", schedState, S_PRE);
        emergency = 1'b0;
        cycle();
        check("release_pending", schedState, S_PEND);
        check("release_wait_zero", dut.wait_cnt, 0);

        // max-wait override while Count is kept below the minimum
        RstCount = 1'b1;
        cycle();
        RstCount = 1'b0;
        cycle();
        cycle();
        k = 0;
        while (farmReq !== 1'b1 && k < 400) begin
            RstCount = (Count == 31'd8);
            cycle();
            k++;
        end
        RstCount = 1'b0;
        check("maxwait_req", farmReq, 1);
        check("maxwait_wait", dut.wait_cnt, MAXW);
        check("maxwait_below_min", (Count < 31'(MING)), 1);

        // wait counter saturation
        emergency = 1'b1;
        hwyGreen  = 1'b0;
        cycle();
        emergency = 1'b0;
        cycle();
        check("sat_pending", schedState, S_PEND);
        repeat (260 * TPS) cycle();
        check("wait_saturated", dut.wait_cnt, 255);
        check("sat_no_req", farmReq, 0);

        // asynchronous reset mid-cycle in PENDING at Count=17
        RstCount = 1'b1;
        cycle();
        RstCount = 1'b0;
        run_until_count("reach_17", 17, 200);
        check("async_pre_state", schedState, S_PEND);
        #2;
        Rst = 1'b1;
        #1;
        check("async_count",   Count, 0);
        check("async_tick",    secTick, 0);
        check("async_req",     farmReq, 0);
        check("async_preempt", preempt, 0);
        check("async_state",   schedState, 0);
        check("async_wait",    dut.wait_cnt, 0);
        cycle();
        Rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            Rst        = ($urandom_range(0, 999) == 0);
            RstCount   = ($urandom_range(0, 99) == 0);
            farmSensor = ($urandom_range(0, 99) < 4);
            pedButton  = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 3) hwyGreen = ~hwyGreen;
            if ($urandom_range(0, 99) < 1) emergency = ~emergency;
            cycle();
        end
        Rst = 1'b0; RstCount = 1'b0; farmSensor = 1'b0; pedButton = 1'b0; emergency = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
